// File: rtl/reg_hazard_tracker_pkg.sv
// Shared types for the ID-stage hazard tracker: forwarding select codes,
// pipeline stage records and the register address width.
package reg_hazard_tracker_pkg;

    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic          wb_en;
        logic          mem_r_en;
    } stage_rec_t;

    typedef struct packed {
        stage_rec_t    rec;
        logic [AW-1:0] src1;
        logic [AW-1:0] src2;
        logic          use_src2;
    } exe_rec_t;

    // One-hot of the destination a record will write; r0 never counts.
    function automatic logic [NREG-1:0] dest_onehot(input stage_rec_t r);
        logic [NREG-1:0] v;
        v = '0;
        if (r.valid && r.wb_en && (r.dest != '0))
            v[r.dest] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_hazard_tracker_if.sv
// ID-stage bundle between the decoder (master) and the hazard tracker (slave).
// Carries ID instruction fields in, stall / forward selects / busy_vec out.
interface reg_hazard_tracker_if
    import reg_hazard_tracker_pkg::*;
;
    logic            id_valid;
    logic [AW-1:0]   id_src1;
    logic [AW-1:0]   id_src2;
    logic            id_use_src2;
    logic [AW-1:0]   id_dest;
    logic            id_wb_en;
    logic            id_mem_r_en;
    logic            fwd_en;
    logic            flush;
    logic            hazard_stall;
    fwd_sel_t        fwd_sel1;
    fwd_sel_t        fwd_sel2;
    logic [NREG-1:0] busy_vec;

    modport master (
        output id_valid, id_src1, id_src2, id_use_src2,
        output id_dest, id_wb_en, id_mem_r_en, fwd_en, flush,
        input  hazard_stall, fwd_sel1, fwd_sel2, busy_vec
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use_src2,
        input  id_dest, id_wb_en, id_mem_r_en, fwd_en, flush,
        output hazard_stall, fwd_sel1, fwd_sel2, busy_vec
    );

endinterface

// File: rtl/reg_hazard_match.sv
// Compares one source address with one stage record's destination.
// Ports: src, valid, wb_en, dest in; hit out (r0 never hits).
module reg_hazard_match
    import reg_hazard_tracker_pkg::*;
(
    input  logic [AW-1:0] src,
    input  logic          valid,
    input  logic          wb_en,
    input  logic [AW-1:0] dest,
    output logic          hit
);

    assign hit = valid & wb_en & (dest != '0) & (dest == src);

endmodule

// File: rtl/reg_hazard_tracker.sv
// ID-stage RAW hazard tracker: EXE/MEM/WB records, stall and forward selects.
// Ports: clk, rst (sync, active-low), bus (slave side of the ID bundle).
module reg_hazard_tracker
    import reg_hazard_tracker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    reg_hazard_tracker_if.slave  bus
);

    exe_rec_t   exe_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;

    logic id1_exe, id2_exe, id1_mem, id2_mem;
    logic ex1_mem, ex2_mem, ex1_wb, ex2_wb;
    logic exe_hit, mem_hit, stall_raw, stall;
    fwd_sel_t sel1, sel2;

    reg_hazard_match u_id1_exe (
        .src(bus.id_src1), .valid(exe_q.rec.valid), .wb_en(exe_q.rec.wb_en),
        .dest(exe_q.rec.dest), .hit(id1_exe)
    );
    reg_hazard_match u_id2_exe (
        .src(bus.id_src2), .valid(exe_q.rec.valid), .wb_en(exe_q.rec.wb_en),
        .dest(exe_q.rec.dest), .hit(id2_exe)
    );
    reg_hazard_match u_id1_mem (
        .src(bus.id_src1), .valid(mem_q.valid), .wb_en(mem_q.wb_en),
        .dest(mem_q.dest), .hit(id1_mem)
    );
    reg_hazard_match u_id2_mem (
        .src(bus.id_src2), .valid(mem_q.valid), .wb_en(mem_q.wb_en),
        .dest(mem_q.dest), .hit(id2_mem)
    );
    reg_hazard_match u_ex1_mem (
        .src(exe_q.src1), .valid(mem_q.valid), .wb_en(mem_q.wb_en),
        .dest(mem_q.dest), .hit(ex1_mem)
    );
    reg_hazard_match u_ex2_mem (
        .src(exe_q.src2), .valid(mem_q.valid), .wb_en(mem_q.wb_en),
        .dest(mem_q.dest), .hit(ex2_mem)
    );
    reg_hazard_match u_ex1_wb (
        .src(exe_q.src1), .valid(wb_q.valid), .wb_en(wb_q.wb_en),
        .dest(wb_q.dest), .hit(ex1_wb)
    );
    reg_hazard_match u_ex2_wb (
        .src(exe_q.src2), .valid(wb_q.valid), .wb_en(wb_q.wb_en),
        .dest(wb_q.dest), .hit(ex2_wb)
    );

    assign exe_hit = id1_exe | (bus.id_use_src2 & id2_exe);
    assign mem_hit = id1_mem | (bus.id_use_src2 & id2_mem);

    // With forwarding only a load in EXE is too late; WB is covered by the
    // falling-edge register file write.
    assign stall_raw = bus.fwd_en ? (exe_hit & exe_q.rec.mem_r_en)
                                  : (exe_hit | mem_hit);

    assign stall = rst & bus.id_valid & ~bus.flush & stall_raw;

    always_comb begin
        sel1 = FWD_REG;
        sel2 = FWD_REG;
        if (rst && bus.fwd_en && exe_q.rec.valid) begin
            if (ex1_mem)
                sel1 = FWD_MEM;
            else if (ex1_wb)
                sel1 = FWD_WB;
            if (exe_q.use_src2) begin
                if (ex2_mem)
                    sel2 = FWD_MEM;
                else if (ex2_wb)
                    sel2 = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= exe_q.rec;
            if (bus.id_valid && !stall && !bus.flush) begin
                exe_q.rec.valid    <= 1'b1;
                exe_q.rec.dest     <= bus.id_dest;
                exe_q.rec.wb_en    <= bus.id_wb_en;
                exe_q.rec.mem_r_en <= bus.id_mem_r_en;
                exe_q.src1         <= bus.id_src1;
                exe_q.src2         <= bus.id_src2;
                exe_q.use_src2     <= bus.id_use_src2;
            end else begin
                exe_q <= '0;
            end
        end
    end

    assign bus.hazard_stall = stall;
    assign bus.fwd_sel1     = sel1;
    assign bus.fwd_sel2     = sel2;
    assign bus.busy_vec     = rst ? (dest_onehot(exe_q.rec) | dest_onehot(mem_q))
                                  : '0;

endmodule

// File: tb/tb_reg_hazard_tracker.sv
// Directed bench for reg_hazard_tracker: forwarding, load-use, stall-only,
// r0, flush and mid-stream reset scenarios with hand-computed expectations.
module tb_reg_hazard_tracker;
    import reg_hazard_tracker_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_hazard_tracker_if bus ();

    reg_hazard_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s1,
                         input logic [4:0] s2, input logic u2,
                         input logic [4:0] d, input logic wb,
                         input logic ld);
        bus.id_valid    = v;
        bus.id_src1     = s1;
        bus.id_src2     = s2;
        bus.id_use_src2 = u2;
        bus.id_dest     = d;
        bus.id_wb_en    = wb;
        bus.id_mem_r_en = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.fwd_en = 1'b1;
        bus.flush  = 1'b0;
        idle();
        tick();

        // Reset holds outputs at zero even with a real instruction in ID.
        drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
        settle();
        check("rst_stall", {31'd0, bus.hazard_stall}, 32'd0);
        check("rst_sel1", {30'd0, bus.fwd_sel1}, 32'd0);
        check("rst_busy", bus.busy_vec, 32'd0);
        tick();
        idle();
        tick();
        rst = 1'b1;

        // 1: ADD r3 then SUB r3 -> MEM forward; with a gap -> WB forward.
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
        settle();
        check("t1_nostall", {31'd0, bus.hazard_stall}, 32'd0);
        check("t1_busy_a", bus.busy_vec, 32'h0000_0008);
        tick();
        idle();
        settle();
        check("t1_sel1_mem", {30'd0, bus.fwd_sel1}, 32'd1);
        check("t1_sel2_reg", {30'd0, bus.fwd_sel2}, 32'd0);
        check("t1_busy_b", bus.busy_vec, 32'h0000_0108);
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        settle();
        check("t1_nostall2", {31'd0, bus.hazard_stall}, 32'd0);
        tick();
        idle();
        settle();
        check("t1_sel1_wb", {30'd0, bus.fwd_sel1}, 32'd2);
        tick();

        // 2: LW r5 then ADD src2=r5 -> one stall cycle, then WB forward.
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd1, 5'd5, 1'b1, 5'd12, 1'b1, 1'b0);
        settle();
        check("t2_stall", {31'd0, bus.hazard_stall}, 32'd1);
        tick();
        settle();
        check("t2_stall_end", {31'd0, bus.hazard_stall}, 32'd0);
        tick();
        idle();
        settle();
        check("t2_sel2_wb", {30'd0, bus.fwd_sel2}, 32'd2);
        check("t2_sel1_reg", {30'd0, bus.fwd_sel1}, 32'd0);
        tick();

        // 3: stall-only mode, ADDI r7 then ADD r7 -> two stall cycles.
        bus.fwd_en = 1'b0;
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        settle();
        check("t3_first", {31'd0, bus.hazard_stall}, 32'd0);
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        settle();
        check("t3_stall_exe", {31'd0, bus.hazard_stall}, 32'd1);
        tick();
        settle();
        check("t3_stall_mem", {31'd0, bus.hazard_stall}, 32'd1);
        check("t3_sel1", {30'd0, bus.fwd_sel1}, 32'd0);
        bus.fwd_en = 1'b1;
        #1;
        check("t3_toggle_fwd", {31'd0, bus.hazard_stall}, 32'd0);
        bus.fwd_en = 1'b0;
        tick();
        settle();
        check("t3_stall_wb", {31'd0, bus.hazard_stall}, 32'd0);
        tick();
        idle();
        settle();
        check("t3_sel1_exe", {30'd0, bus.fwd_sel1}, 32'd0);
        tick();

        // 4: writers of r0 never create hazards or busy bits.
        bus.fwd_en = 1'b1;
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd14, 1'b0, 1'b0);
        settle();
        check("t4_stall", {31'd0, bus.hazard_stall}, 32'd0);
        check("t4_busy_a", bus.busy_vec, 32'd0);
        tick();
        idle();
        settle();
        check("t4_sel1", {30'd0, bus.fwd_sel1}, 32'd0);
        check("t4_sel2", {30'd0, bus.fwd_sel2}, 32'd0);
        check("t4_busy_b", bus.busy_vec, 32'd0);
        tick();

        // 5: load-use collides with flush; flush wins.
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        settle();
        check("t5_noflush", {31'd0, bus.hazard_stall}, 32'd1);
        bus.flush = 1'b1;
        #1;
        check("t5_flush", {31'd0, bus.hazard_stall}, 32'd0);
        check("t5_busy_a", bus.busy_vec, 32'h0000_0200);
        tick();
        bus.flush = 1'b0;
        idle();
        settle();
        check("t5_busy_b", bus.busy_vec, 32'h0000_0200);
        check("t5_bubble", {30'd0, bus.fwd_sel1}, 32'd0);
        tick();
        settle();
        check("t5_busy_c", bus.busy_vec, 32'd0);
        tick();

        // 6: two loads in flight, then reset drops them.
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd4, 5'd6, 1'b0, 5'd16, 1'b1, 1'b0);
        settle();
        check("t6_pre_stall", {31'd0, bus.hazard_stall}, 32'd1);
        check("t6_pre_busy", bus.busy_vec, 32'h0000_0050);
        rst = 1'b0;
        #1;
        check("t6_rst_stall", {31'd0, bus.hazard_stall}, 32'd0);
        tick();
        rst = 1'b1;
        settle();
        check("t6_post_stall", {31'd0, bus.hazard_stall}, 32'd0);
        check("t6_post_busy", bus.busy_vec, 32'd0);
        check("t6_post_sel1", {30'd0, bus.fwd_sel1}, 32'd0);
        check("t6_post_sel2", {30'd0, bus.fwd_sel2}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_hazard_tracker.md
Name: reg_hazard_tracker

Overview:
- Reader-side companion to the register file: sits in the ID stage, watches the src1/src2 addresses the decoder presents to the register file, and tracks in-flight destination writes through EXE/MEM/WB.
- Asserts a stall when a read would return stale data.
- Registers the sources into an EXE-stage shadow and produces forwarding selects for the EXE operand muxes.
- Register 0 is never a hazard. The register file writes on the falling edge, so a WB-stage write is visible to a same-cycle ID read.

Parameters:
- AW, 5, register address width (32 registers).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-low reset (rst=0 resets on the rising clk edge)
- id_valid  input  1  a real instruction occupies ID
- id_src1  input  AW  first source address, same value driven to the register file src1
- id_src2  input  AW  second source address
- id_use_src2  input  1  instruction actually reads src2 (R-type, store, branch)
- id_dest  input  AW  destination of the ID instruction
- id_wb_en  input  1  ID instruction writes the register file
- id_mem_r_en  input  1  ID instruction is a load
- fwd_en  input  1  1 = forwarding enabled, 0 = stall-only mode
- flush  input  1  taken branch; discard the ID instruction
- hazard_stall  output  1  hold PC and IF/ID; insert a bubble into EXE
- fwd_sel1  output  2  EXE operand-1 source: 00 register value, 01 MEM-stage ALU result, 10 WB-stage write value
- fwd_sel2  output  2  EXE operand-2 source, same encoding
- busy_vec  output  2**AW  bit r = 1 while an in-flight instruction in EXE or MEM will write r

Behaviour:
- State: three stage records, EXE, MEM and WB. Each record holds {valid, dest, wb_en, mem_r_en}. EXE also holds {src1, src2, use_src2}.
- Reset (rst=0 at the rising edge):
  - all records invalid, all fields 0.
  - Outputs while rst=0: hazard_stall=0, fwd_sel1=fwd_sel2=00, busy_vec=0.
- Match definition: match(s, X) = X.valid & X.wb_en & (X.dest != 0) & (X.dest == s).
- ID source check: src1 always counts; src2 counts only when id_use_src2=1.
- Stall (combinational, qualified by id_valid & ~flush):
  - fwd_en=0: stall if either counted source matches EXE or MEM.
  - fwd_en=1: stall only if a counted source matches EXE and EXE.mem_r_en=1 (load-use).
  - WB never causes a stall.
- Advance every rising edge:
  - WB <= MEM, MEM <= EXE.
  - EXE <= ID fields with valid = id_valid & ~hazard_stall & ~flush; otherwise EXE receives a bubble (valid=0, all fields 0).
  - No global freeze exists; MEM and WB always advance.
- Forwarding (combinational from the EXE record):
  - fwd_en=0: fwd_sel=00.
  - fwd_sel1 = 01 if match(EXE.src1, MEM); else 10 if match(EXE.src1, WB); else 00.
  - fwd_sel2 is the same using EXE.src2, gated by EXE.use_src2.
  - MEM has priority over WB.
  - Invalid EXE gives 00.
- busy_vec = OR of one-hot(dest) for EXE and MEM where valid & wb_en & dest!=0. Bit 0 is always 0.
- Boundaries:
  - dest 0 never matches and never sets busy.
  - Both sources hitting different stages are resolved independently.
  - Stall and flush in the same cycle: flush wins, hazard_stall=0, bubble inserted.
  - A load-use stall lasts exactly 1 cycle with fwd_en=1. It lasts up to 2 cycles with fwd_en=0 (EXE hit, then MEM hit).
  - Reset mid-stream drops all in-flight records; the first post-reset cycle never stalls.
  - A toggled fwd_en takes effect combinationally the same cycle.

Decomposition:
- Shared package:
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - Stage-record struct type.
  - AW constant shared with the register file.
- One sub-module is natural: reg_hazard_match (combinational; one source, one record → hit). It is instantiated for each source/stage pair.

Test Plan:
1. Reset, then ADD r3 (dest 3, wb_en) followed next cycle by SUB reading src1=3, fwd_en=1 → no stall; when SUB is in EXE, fwd_sel1=01. Same pair with one independent instruction between → fwd_sel1=10.
2. LW r5 followed by ADD src2=5, use_src2=1, fwd_en=1 → hazard_stall=1 for exactly 1 cycle; after the bubble, ADD in EXE shows fwd_sel2=10.
3. fwd_en=0: ADDI r7, then ADD src1=7 → stall 2 cycles (EXE hit, then MEM hit). Stall deasserts when r7 reaches WB; fwd_sel1=00 throughout.
4. Writes to r0 (dest 0, wb_en=1), then a reader of src1=0 and src2=0 → never stall, fwd_sel=00, busy_vec=0.
5. LW r9 then reader of r9 with flush=1 in the same cycle → hazard_stall=0; EXE receives a bubble; busy_vec[9] clears 2 cycles after the LW left ID.
6. Two loads in flight (r4 in EXE, r6 in MEM), then rst=0 for one cycle → next cycle busy_vec=0, fwd_sel=00, and a reader of r4 does not stall.
